icb_arbiter: RTL and testbench
==============================

# icb_arbiter

N-to-1 arbiter sharing one ICB slave port (for example, the SRAM slave) among several ICB masters. It arbitrates commands and tracks in-flight commands in an ID FIFO. Each response is routed back to the master that issued the matching command, in issue order. The command and response paths are combinational pass-throughs, so the block adds zero cycles of latency.

## Interface
- `N_MASTERS`, 2 — number of requesting masters (2..8).
- `AW`, 32 — address width.
- `DW`, 32 — data width; the write mask is `DW/8` bits.
- `OUTS_DEPTH`, 4 — maximum outstanding commands; must be a power of 2 and at least 1.

- `clk`  in  1  — single clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `m_icb_cmd_valid`  in  N_MASTERS  — per-master command valid.
- `m_icb_cmd_ready`  out  N_MASTERS  — per-master command ready.
- `m_icb_cmd_addr`  in  N_MASTERS*AW  — packed; master i occupies bits `[i*AW +: AW]`.
- `m_icb_cmd_read`  in  N_MASTERS  — 1 = read, 0 = write.
- `m_icb_cmd_wdata`  in  N_MASTERS*DW  — packed write data.
- `m_icb_cmd_wmask`  in  N_MASTERS*DW/8  — packed byte mask.
- `m_icb_rsp_valid`  out  N_MASTERS  — per-master response valid.
- `m_icb_rsp_ready`  in  N_MASTERS  — per-master response ready.
- `m_icb_rsp_rdata`  out  DW  — shared read data; qualified by `m_icb_rsp_valid[i]`.
- `m_icb_rsp_err`  out  1  — shared error; qualified by `m_icb_rsp_valid[i]`.
- `s_icb_cmd_valid` / `s_icb_cmd_ready` / `s_icb_cmd_addr` / `s_icb_cmd_read` / `s_icb_cmd_wdata` / `s_icb_cmd_wmask`  — slave-side command channel; `valid` and payload are outputs, `ready` is an input.
- `s_icb_rsp_valid` / `s_icb_rsp_ready` / `s_icb_rsp_rdata` / `s_icb_rsp_err`  — slave-side response channel; `ready` is an output, the rest are inputs.
- `arb_err`  out  1  — sticky flag: a slave response arrived while nothing was outstanding.

## Operation
- **Grant selection**
  - With no lock held, `gnt` = the winning requester among `m_icb_cmd_valid`, chosen per Configuration.
  - The slave command payload is muxed from master `gnt`.
  - `s_icb_cmd_valid` = `|m_icb_cmd_valid & ~fifo_full`.
  - `m_icb_cmd_ready[gnt]` = `s_icb_cmd_ready & ~fifo_full`; all other bits of `m_icb_cmd_ready` are 0.
- **Lock**
  - If `s_icb_cmd_valid && !s_icb_cmd_ready`, register `lock=1` and `lock_id=gnt`.
  - While locked, `gnt=lock_id` regardless of other requests.
  - The lock clears on the handshake of the locked master.
  - Masters hold `valid` and payload stable until accepted, per ICB rules.
- **ID FIFO** (depth `OUTS_DEPTH`, width `clog2(N_MASTERS)`)
  - Push `gnt` on each slave command handshake.
  - Pop on each slave response handshake.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - When full, commands are blocked, including in a cycle where a pop also occurs. The block never pushes to a full FIFO.
- **Response routing**
  - `head` = FIFO head ID.
  - `m_icb_rsp_valid[head]` = `s_icb_rsp_valid & ~fifo_empty`.
  - `s_icb_rsp_ready` = `m_icb_rsp_ready[head]` when the FIFO is non-empty.
  - `rdata` and `err` pass through unchanged.
- **Response with FIFO empty**
  - `s_icb_rsp_ready=1`; the response is dropped.
  - No `m_icb_rsp_valid` bit is asserted.
  - `arb_err` is set and stays set until reset.

## Timing
- Command and response paths: 0-cycle combinational latency. No combinational path exists from `s_icb_cmd_ready` to `gnt`.
- State (lock, RR pointer, FIFO pointers/count, `arb_err`) updates on the rising edge of `clk`.
- Reset values:
  - all `m_icb_cmd_ready`, `m_icb_rsp_valid` = 0; `s_icb_cmd_valid` = 0; `arb_err` = 0;
  - lock = 0; RR pointer = 0; FIFO empty.
  - `s_icb_rsp_ready` resets to 1, because the empty-FIFO drop rule applies.
- Reset asserted mid-transaction: all in-flight IDs are discarded immediately. Slave responses arriving after reset are treated as empty-FIFO responses.
- Back-to-back: one command per cycle is sustained while `s_icb_cmd_ready=1` and the FIFO is not full.

## Configuration
- Macro: `ICB_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - The pointer starts at 0.
  - After a handshake by master i, the pointer becomes `(i+1) mod N_MASTERS`.
  - The winner is the first requester at or after the pointer.
- Undefined: fixed priority; the lowest index wins and no pointer is kept. Lock behaviour and the FIFO are identical in both builds.

## Test plan
- **Single write:** M0 writes `addr=0x10`, `data=0xDEADBEEF`, `wmask=0xF` -> slave sees exactly that in one cycle; its response routes only to `m_icb_rsp_valid[0]`.
- **Contention (RR build):** M0 and M1 request continuously, slave always ready -> grants alternate 0,1,0,1; without the macro all grants go to 0.
- **Lock:** M1 is granted, slave holds `cmd_ready=0` for 3 cycles while M0 also requests -> `gnt` stays 1 until the handshake; M0 is then granted.
- **Outstanding limit:** `OUTS_DEPTH=4`, slave delays all responses -> 4 commands accepted, 5th blocked (`m_icb_cmd_ready=0`). One response frees a slot; the next cycle accepts the command.
- **Ordering:** M0 reads `0x10`, then M1 reads `0x24`; slave returns `0xDEADBEEF` then `0x12345678` -> the first goes to M0, the second to M1. M1 `rsp_ready=0` stalls `s_icb_rsp_ready`.
- **Spurious response / reset:** slave `rsp_valid` with FIFO empty -> `arb_err=1`, no master valid. Assert `rst_n=0` with 2 commands outstanding -> FIFO empty and `arb_err=0` after reset.

Source files
------------

// File: rtl/icb_arbiter.sv
// icb_arbiter: N-to-1 ICB arbiter sharing one slave port among several masters.
// Commands and responses pass through combinationally, so the block adds no
// latency. An ID FIFO records which master issued each accepted command.
// Responses are routed back to that master in issue order.
// Optional feature macro: ICB_ARB_RR_EN selects round-robin arbitration.
// When the macro is undefined, arbitration is fixed priority (lowest index wins).
module icb_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MASTERS-1:0]        m_icb_cmd_valid,
    output logic [N_MASTERS-1:0]        m_icb_cmd_ready,
    input  logic [N_MASTERS*AW-1:0]     m_icb_cmd_addr,
    input  logic [N_MASTERS-1:0]        m_icb_cmd_read,
    input  logic [N_MASTERS*DW-1:0]     m_icb_cmd_wdata,
    input  logic [N_MASTERS*DW/8-1:0]   m_icb_cmd_wmask,
    output logic [N_MASTERS-1:0]        m_icb_rsp_valid,
    input  logic [N_MASTERS-1:0]        m_icb_rsp_ready,
    output logic [DW-1:0]               m_icb_rsp_rdata,
    output logic                        m_icb_rsp_err,
    output logic                        s_icb_cmd_valid,
    input  logic                        s_icb_cmd_ready,
    output logic [AW-1:0]               s_icb_cmd_addr,
    output logic                        s_icb_cmd_read,
    output logic [DW-1:0]               s_icb_cmd_wdata,
    output logic [DW/8-1:0]             s_icb_cmd_wmask,
    input  logic                        s_icb_rsp_valid,
    output logic                        s_icb_rsp_ready,
    input  logic [DW-1:0]               s_icb_rsp_rdata,
    input  logic                        s_icb_rsp_err,
    output logic                        arb_err
);

    localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PW  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW  = $clog2(OUTS_DEPTH + 1);
    localparam int MW  = DW / 8;

    // FIFO pointer increment; a single-entry FIFO keeps its pointer at zero.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (OUTS_DEPTH == 1) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Lock state and ID FIFO state
    logic                 r_lock;
    logic [IDW-1:0]       r_lock_id;
    logic [IDW-1:0]       r_fifo_mem [OUTS_DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_cnt;
    logic                 r_arb_err;

    logic                 w_any_valid;
    logic                 w_full;
    logic                 w_empty;
    logic [IDW-1:0]       w_arb_gnt;
    logic                 w_found;
    logic [IDW-1:0]       w_gnt;
    logic [IDW-1:0]       w_head;
    logic                 w_push;
    logic                 w_pop;

`ifdef ICB_ARB_RR_EN
    logic [IDW-1:0]       r_rr_ptr;
`endif

    assign w_any_valid = |m_icb_cmd_valid;
    assign w_full      = (r_cnt == CW'(OUTS_DEPTH));
    assign w_empty     = (r_cnt == {CW{1'b0}});
    assign w_head      = r_fifo_mem[r_rptr];
    assign w_gnt       = r_lock ? r_lock_id : w_arb_gnt;
    assign w_push      = s_icb_cmd_valid & s_icb_cmd_ready;
    assign w_pop       = s_icb_rsp_valid & s_icb_rsp_ready & ~w_empty;
    assign arb_err     = r_arb_err;

    // Pick the unlocked winner from the request vector only (independent of slave ready).
    always_comb begin
        w_arb_gnt = {IDW{1'b0}};
        w_found   = 1'b0;
`ifdef ICB_ARB_RR_EN
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!w_found && m_icb_cmd_valid[(int'(r_rr_ptr) + k) % N_MASTERS]) begin
                w_arb_gnt = IDW'((int'(r_rr_ptr) + k) % N_MASTERS);
                w_found   = 1'b1;
            end else begin
                w_found   = w_found;
            end
        end
`else
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!w_found && m_icb_cmd_valid[k]) begin
                w_arb_gnt = IDW'(k);
                w_found   = 1'b1;
            end else begin
                w_found   = w_found;
            end
        end
`endif
    end

    // Mux the granted master's payload onto the slave command channel and steer ready back.
    always_comb begin
        s_icb_cmd_valid = w_any_valid & ~w_full;
        s_icb_cmd_addr  = m_icb_cmd_addr[int'(w_gnt)*AW +: AW];
        s_icb_cmd_read  = m_icb_cmd_read[w_gnt];
        s_icb_cmd_wdata = m_icb_cmd_wdata[int'(w_gnt)*DW +: DW];
        s_icb_cmd_wmask = m_icb_cmd_wmask[int'(w_gnt)*MW +: MW];
        m_icb_cmd_ready = {N_MASTERS{1'b0}};
        if (w_any_valid) begin
            m_icb_cmd_ready[w_gnt] = s_icb_cmd_ready & ~w_full;
        end else begin
            m_icb_cmd_ready = {N_MASTERS{1'b0}};
        end
    end

    // Route the slave response to the FIFO head master; with nothing outstanding, drop it.
    always_comb begin
        m_icb_rsp_valid = {N_MASTERS{1'b0}};
        m_icb_rsp_rdata = s_icb_rsp_rdata;
        m_icb_rsp_err   = s_icb_rsp_err;
        if (w_empty) begin
            s_icb_rsp_ready = 1'b1;
        end else begin
            m_icb_rsp_valid[w_head] = s_icb_rsp_valid;
            s_icb_rsp_ready         = m_icb_rsp_ready[w_head];
        end
    end

    // Hold the grant on a master whose command the slave is stalling until it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_id <= {IDW{1'b0}};
        end else if (w_push) begin
            r_lock    <= 1'b0;
        end else if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_gnt;
        end else begin
            r_lock    <= r_lock;
        end
    end

`ifdef ICB_ARB_RR_EN
    // Advance the round-robin pointer past the master that just completed a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= {IDW{1'b0}};
        end else if (w_push) begin
            if (int'(w_gnt) == N_MASTERS - 1) begin
                r_rr_ptr <= {IDW{1'b0}};
            end else begin
                r_rr_ptr <= w_gnt + IDW'(1);
            end
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

    // ID FIFO: push the granted ID on command handshake, pop on response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
            r_cnt  <= {CW{1'b0}};
            for (int i = 0; i < OUTS_DEPTH; i++) begin
                r_fifo_mem[i] <= {IDW{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wptr] <= w_gnt;
                r_wptr             <= ptr_inc(r_wptr);
            end else begin
                r_wptr             <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end else begin
                r_rptr <= r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky flag for a slave response arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arb_err <= 1'b0;
        end else if (s_icb_rsp_valid && w_empty) begin
            r_arb_err <= 1'b1;
        end else begin
            r_arb_err <= r_arb_err;
        end
    end

endmodule

// File: tb/tb_icb_arbiter.sv
// Directed self-checking bench for icb_arbiter (2 masters, depth 4).
// Expected grant order in the contention step depends on ICB_ARB_RR_EN.
module tb_icb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_icb_cmd_valid;
    logic [1:0]  m_icb_cmd_ready;
    logic [63:0] m_icb_cmd_addr;
    logic [1:0]  m_icb_cmd_read;
    logic [63:0] m_icb_cmd_wdata;
    logic [7:0]  m_icb_cmd_wmask;
    logic [1:0]  m_icb_rsp_valid;
    logic [1:0]  m_icb_rsp_ready;
    logic [31:0] m_icb_rsp_rdata;
    logic        m_icb_rsp_err;
    logic        s_icb_cmd_valid;
    logic        s_icb_cmd_ready;
    logic [31:0] s_icb_cmd_addr;
    logic        s_icb_cmd_read;
    logic [31:0] s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_rsp_valid;
    logic        s_icb_rsp_ready;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        arb_err;

    int vectors     = 0;
    int miscompares = 0;
    logic [1:0] exp_gnt [4];

    icb_arbiter #(.N_MASTERS(2), .AW(32), .DW(32), .OUTS_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_icb_cmd_valid (m_icb_cmd_valid),
        .m_icb_cmd_ready (m_icb_cmd_ready),
        .m_icb_cmd_addr  (m_icb_cmd_addr),
        .m_icb_cmd_read  (m_icb_cmd_read),
        .m_icb_cmd_wdata (m_icb_cmd_wdata),
        .m_icb_cmd_wmask (m_icb_cmd_wmask),
        .m_icb_rsp_valid (m_icb_rsp_valid),
        .m_icb_rsp_ready (m_icb_rsp_ready),
        .m_icb_rsp_rdata (m_icb_rsp_rdata),
        .m_icb_rsp_err   (m_icb_rsp_err),
        .s_icb_cmd_valid (s_icb_cmd_valid),
        .s_icb_cmd_ready (s_icb_cmd_ready),
        .s_icb_cmd_addr  (s_icb_cmd_addr),
        .s_icb_cmd_read  (s_icb_cmd_read),
        .s_icb_cmd_wdata (s_icb_cmd_wdata),
        .s_icb_cmd_wmask (s_icb_cmd_wmask),
        .s_icb_rsp_valid (s_icb_rsp_valid),
        .s_icb_rsp_ready (s_icb_rsp_ready),
        .s_icb_rsp_rdata (s_icb_rsp_rdata),
        .s_icb_rsp_err   (s_icb_rsp_err),
        .arb_err         (arb_err)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    // Linear directed sequence.
    initial begin
`ifdef ICB_ARB_RR_EN
        exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`endif
        rst_n = 1'b0;
        m_icb_cmd_valid = 2'b00; m_icb_cmd_addr = 64'h0; m_icb_cmd_read = 2'b00;
        m_icb_cmd_wdata = 64'h0; m_icb_cmd_wmask = 8'h00; m_icb_rsp_ready = 2'b11;
        s_icb_cmd_ready = 1'b1; s_icb_rsp_valid = 1'b0; s_icb_rsp_rdata = 32'h0;
        s_icb_rsp_err = 1'b0;
        settle();
        // Reset state
        chk("rst_m_cmd_ready", 64'(m_icb_cmd_ready), 64'h0);
        chk("rst_m_rsp_valid", 64'(m_icb_rsp_valid), 64'h0);
        chk("rst_s_cmd_valid", 64'(s_icb_cmd_valid), 64'h0);
        chk("rst_arb_err",     64'(arb_err),         64'h0);
        chk("rst_s_rsp_ready", 64'(s_icb_rsp_ready), 64'h1);
        step();
        rst_n = 1'b1;
        step();

        // Single write from M0
        m_icb_cmd_valid = 2'b01;
        m_icb_cmd_addr  = {32'h0000_0099, 32'h0000_0010};
        m_icb_cmd_wdata = {32'h5555_5555, 32'hDEAD_BEEF};
        m_icb_cmd_wmask = 8'h3F;
        m_icb_cmd_read  = 2'b10;
        settle();
        chk("wr_s_valid", 64'(s_icb_cmd_valid), 64'h1);
        chk("wr_s_addr",  64'(s_icb_cmd_addr),  64'h10);
        chk("wr_s_wdata", 64'(s_icb_cmd_wdata), 64'hDEADBEEF);
        chk("wr_s_wmask", 64'(s_icb_cmd_wmask), 64'hF);
        chk("wr_s_read",  64'(s_icb_cmd_read),  64'h0);
        chk("wr_m_ready", 64'(m_icb_cmd_ready), 64'h1);
        step();
        m_icb_cmd_valid = 2'b00;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_err = 1'b1; s_icb_rsp_rdata = 32'hA5A5_0001;
        settle();
        chk("wr_rsp_route", 64'(m_icb_rsp_valid), 64'h1);
        chk("wr_rsp_err",   64'(m_icb_rsp_err),   64'h1);
        chk("wr_rsp_rdata", 64'(m_icb_rsp_rdata), 64'hA5A50001);
        chk("wr_s_rsp_rdy", 64'(s_icb_rsp_ready), 64'h1);
        step();
        s_icb_rsp_valid = 1'b0; s_icb_rsp_err = 1'b0;

        // Contention: both masters request, slave always ready, responses stream back
        m_icb_cmd_valid = 2'b11;
        m_icb_cmd_addr  = {32'h0000_0200, 32'h0000_0100};
        settle();
        chk("cont_g0", 64'(m_icb_cmd_ready), 64'(exp_gnt[0]));
        step();
        s_icb_rsp_valid = 1'b1;
        settle();
        chk("cont_g1",   64'(m_icb_cmd_ready), 64'(exp_gnt[1]));
        chk("cont_rsp0", 64'(m_icb_rsp_valid), 64'(exp_gnt[0]));
        step();
        chk("cont_g2", 64'(m_icb_cmd_ready), 64'(exp_gnt[2]));
        step();
        chk("cont_g3", 64'(m_icb_cmd_ready), 64'(exp_gnt[3]));
        step();
        m_icb_cmd_valid = 2'b00;
        settle();
        chk("cont_rsp3", 64'(m_icb_rsp_valid), 64'(exp_gnt[3]));
        step();
        s_icb_rsp_valid = 1'b0;

        // Lock: M1 stalled by slave for 3 cycles while M0 joins
        m_icb_cmd_addr  = {32'h0000_0124, 32'h0000_0010};
        m_icb_cmd_valid = 2'b10;
        s_icb_cmd_ready = 1'b0;
        settle();
        chk("lock_c0_addr", 64'(s_icb_cmd_addr), 64'h124);
        step();
        m_icb_cmd_valid = 2'b11;
        settle();
        chk("lock_c1_addr",  64'(s_icb_cmd_addr),  64'h124);
        chk("lock_c1_ready", 64'(m_icb_cmd_ready), 64'h0);
        chk("lock_c1_valid", 64'(s_icb_cmd_valid), 64'h1);
        step();
        chk("lock_c2_addr", 64'(s_icb_cmd_addr), 64'h124);
        step();
        s_icb_cmd_ready = 1'b1;
        settle();
        chk("lock_hs_ready", 64'(m_icb_cmd_ready), 64'h2);
        chk("lock_hs_addr",  64'(s_icb_cmd_addr),  64'h124);
        step();
        m_icb_cmd_valid = 2'b01;
        settle();
        chk("lock_m0_ready", 64'(m_icb_cmd_ready), 64'h1);
        chk("lock_m0_addr",  64'(s_icb_cmd_addr),  64'h10);
        step();
        m_icb_cmd_valid = 2'b00;
        s_icb_rsp_valid = 1'b1;
        settle();
        chk("lock_rsp_m1", 64'(m_icb_rsp_valid), 64'h2);
        step();
        chk("lock_rsp_m0", 64'(m_icb_rsp_valid), 64'h1);
        step();
        s_icb_rsp_valid = 1'b0;

        // Outstanding limit: 4 accepted, 5th blocked, pop then accept
        m_icb_cmd_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("outs_accept", 64'(m_icb_cmd_ready), 64'h1);
            step();
        end
        chk("outs_full_ready", 64'(m_icb_cmd_ready), 64'h0);
        chk("outs_full_valid", 64'(s_icb_cmd_valid), 64'h0);
        s_icb_rsp_valid = 1'b1;
        settle();
        chk("outs_full_pop_ready", 64'(m_icb_cmd_ready), 64'h0);
        step();
        s_icb_rsp_valid = 1'b0;
        settle();
        chk("outs_after_pop", 64'(m_icb_cmd_ready), 64'h1);
        step();
        m_icb_cmd_valid = 2'b00;
        s_icb_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("outs_drain", 64'(m_icb_rsp_valid), 64'h1);
            step();
        end
        s_icb_rsp_valid = 1'b0;
        settle();
        chk("outs_empty_rdy", 64'(s_icb_rsp_ready), 64'h1);

        // Ordering: M0 reads 0x10, then M1 reads 0x24
        m_icb_cmd_addr  = {32'h0000_0024, 32'h0000_0010};
        m_icb_cmd_read  = 2'b11;
        m_icb_cmd_valid = 2'b01;
        step();
        m_icb_cmd_valid = 2'b10;
        settle();
        chk("ord_m1_addr",  64'(s_icb_cmd_addr),  64'h24);
        chk("ord_m1_read",  64'(s_icb_cmd_read),  64'h1);
        chk("ord_m1_ready", 64'(m_icb_cmd_ready), 64'h2);
        step();
        m_icb_cmd_valid = 2'b00;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hDEAD_BEEF;
        settle();
        chk("ord_rsp0_route", 64'(m_icb_rsp_valid), 64'h1);
        chk("ord_rsp0_rdata", 64'(m_icb_rsp_rdata), 64'hDEADBEEF);
        step();
        s_icb_rsp_rdata = 32'h1234_5678; m_icb_rsp_ready = 2'b01;
        settle();
        chk("ord_rsp1_route", 64'(m_icb_rsp_valid), 64'h2);
        chk("ord_rsp1_stall", 64'(s_icb_rsp_ready), 64'h0);
        step();
        chk("ord_rsp1_held", 64'(m_icb_rsp_valid), 64'h2);
        m_icb_rsp_ready = 2'b11;
        settle();
        chk("ord_rsp1_go",    64'(s_icb_rsp_ready), 64'h1);
        chk("ord_rsp1_rdata", 64'(m_icb_rsp_rdata), 64'h12345678);
        step();
        s_icb_rsp_valid = 1'b0;

        // Spurious response with FIFO empty
        s_icb_rsp_valid = 1'b1;
        settle();
        chk("spur_no_valid", 64'(m_icb_rsp_valid), 64'h0);
        chk("spur_ready",    64'(s_icb_rsp_ready), 64'h1);
        chk("spur_err_pre",  64'(arb_err),         64'h0);
        step();
        s_icb_rsp_valid = 1'b0;
        chk("spur_err_set", 64'(arb_err), 64'h1);
        step();
        chk("spur_err_sticky", 64'(arb_err), 64'h1);

        // Reset with two commands outstanding
        m_icb_cmd_valid = 2'b01;
        step();
        step();
        m_icb_cmd_valid = 2'b00;
        m_icb_rsp_ready = 2'b00;
        settle();
        chk("mid_busy_rdy", 64'(s_icb_rsp_ready), 64'h0);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_rdy", 64'(s_icb_rsp_ready), 64'h1);
        chk("mid_rst_err", 64'(arb_err),         64'h0);
        step();
        rst_n = 1'b1;
        step();
        s_icb_rsp_valid = 1'b1;
        settle();
        chk("post_rst_no_valid", 64'(m_icb_rsp_valid), 64'h0);
        chk("post_rst_ready",    64'(s_icb_rsp_ready), 64'h1);
        step();
        s_icb_rsp_valid = 1'b0;
        chk("post_rst_err", 64'(arb_err), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
